// File: rtl/rd_trig_pkg.sv
// Shared types and constants for the radio-detector trigger scheduler.
package rd_trig_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_DEAD  = 2'd2
  } state_t;

  localparam int              CNT_W   = 16;
  localparam logic [CNT_W-1:0] CNT_SAT = 16'hFFFF;

  // Statistics counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [3:0]       b);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + {{(CNT_W-3){1'b0}}, b};
    return sum[CNT_W] ? CNT_SAT : sum[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/rd_rr_arbiter.sv
// Combinational round-robin pick: first pending index at or after ptr, wrapping.
module rd_rr_arbiter
  import rd_trig_pkg::*;
#(
  parameter int NREQ = 4,
  localparam int IW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] pending,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] sel,
  output logic            valid
);

  logic          found;
  logic [IW-1:0] idx;

  always_comb begin
    sel   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IW'((int'(ptr) + k) % NREQ);
      if (!found && pending[idx]) begin
        sel[idx] = 1'b1;
        found    = 1'b1;
      end
    end
    valid = found;
  end

endmodule

// File: rtl/rd_trig_sched.sv
// Round-robin trigger scheduler: one shared output pulse of programmable width
// followed by a programmable dead time, with issued/dropped statistics.
module rd_trig_sched
  import rd_trig_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WBITS = 8,
  parameter int DBITS = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ENABLE,
  input  logic [NREQ-1:0]  REQ,
  input  logic [WBITS-1:0] PULSE_WIDTH,
  input  logic [DBITS-1:0] DEAD_TIME,
  input  logic             CLR_CNT,
  output logic             OUT,
  output logic [NREQ-1:0]  GRANT,
  output logic             BUSY,
  output logic [CNT_W-1:0] TRIG_CNT,
  output logic [CNT_W-1:0] DROP_CNT
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = (WBITS > DBITS) ? WBITS : DBITS;

  state_t          state;
  logic [NREQ-1:0] pending;
  logic [IW-1:0]   ptr;
  logic [CW-1:0]   cnt;

  logic [NREQ-1:0] arb_sel;
  logic            arb_valid;
  logic            do_grant;
  logic [NREQ-1:0] grant_clr;
  logic [NREQ-1:0] dropped;
  logic [NREQ-1:0] pend_next;
  logic [IW-1:0]   sel_idx;
  logic [IW-1:0]   ptr_next;
  logic [3:0]      drop_num;
  logic [CW-1:0]   pw_load;
  logic [CW-1:0]   dead_load;

  rd_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .pending (pending),
    .ptr     (ptr),
    .sel     (arb_sel),
    .valid   (arb_valid)
  );

  // A grant frees its source's pending bit in the same cycle, so a repeat
  // request from that source on the grant edge is kept rather than dropped.
  assign do_grant  = (state == ST_IDLE) && arb_valid && ENABLE;
  assign grant_clr = do_grant ? arb_sel : '0;
  assign dropped   = ENABLE ? (REQ & pending & ~grant_clr) : '0;
  assign pend_next = ENABLE ? ((pending & ~grant_clr) | REQ) : '0;

  assign pw_load   = (PULSE_WIDTH == '0) ? '0 : CW'(PULSE_WIDTH) - CW'(1);
  assign dead_load = CW'(DEAD_TIME) - CW'(1);
  assign ptr_next  = (sel_idx == IW'(NREQ - 1)) ? '0 : sel_idx + IW'(1);

  always_comb begin
    sel_idx  = '0;
    drop_num = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_sel[i]) sel_idx = IW'(i);
      drop_num = drop_num + 4'(dropped[i]);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= ST_IDLE;
      pending  <= '0;
      ptr      <= '0;
      cnt      <= '0;
      OUT      <= 1'b0;
      GRANT    <= '0;
      BUSY     <= 1'b0;
      TRIG_CNT <= '0;
      DROP_CNT <= '0;
    end else begin
      GRANT   <= '0;
      pending <= pend_next;

      if (CLR_CNT) begin
        TRIG_CNT <= '0;
        DROP_CNT <= '0;
      end else begin
        TRIG_CNT <= sat_add(TRIG_CNT, {3'b000, do_grant});
        DROP_CNT <= sat_add(DROP_CNT, drop_num);
      end

      case (state)
        ST_IDLE: begin
          if (do_grant) begin
            GRANT <= arb_sel;
            OUT   <= 1'b1;
            BUSY  <= 1'b1;
            ptr   <= ptr_next;
            cnt   <= pw_load;
            state <= ST_PULSE;
          end
        end
        ST_PULSE: begin
          if (cnt == '0) begin
            OUT <= 1'b0;
            if (DEAD_TIME == '0) begin
              BUSY  <= 1'b0;
              state <= ST_IDLE;
            end else begin
              cnt   <= dead_load;
              state <= ST_DEAD;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ST_DEAD: begin
          if (cnt == '0) begin
            BUSY  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: begin
          OUT   <= 1'b0;
          BUSY  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rd_trig_sched.sv
// Bench for rd_trig_sched: directed scenarios plus random traffic against a
// timestamp-based reference model (grant time, pulse end, idle time).
module tb_rd_trig_sched;

  localparam int NREQ  = 4;
  localparam int WBITS = 8;
  localparam int DBITS = 16;
  localparam int NEVER = 32'h7FFF_FFFF;

  logic             CLK = 1'b0;
  logic             RST;
  logic             ENABLE;
  logic [NREQ-1:0]  REQ;
  logic [WBITS-1:0] PULSE_WIDTH;
  logic [DBITS-1:0] DEAD_TIME;
  logic             CLR_CNT;
  logic             OUT;
  logic [NREQ-1:0]  GRANT;
  logic             BUSY;
  logic [15:0]      TRIG_CNT;
  logic [15:0]      DROP_CNT;

  always #5 CLK = ~CLK;

  rd_trig_sched #(.NREQ(NREQ), .WBITS(WBITS), .DBITS(DBITS)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .ENABLE      (ENABLE),
    .REQ         (REQ),
    .PULSE_WIDTH (PULSE_WIDTH),
    .DEAD_TIME   (DEAD_TIME),
    .CLR_CNT     (CLR_CNT),
    .OUT         (OUT),
    .GRANT       (GRANT),
    .BUSY        (BUSY),
    .TRIG_CNT    (TRIG_CNT),
    .DROP_CNT    (DROP_CNT)
  );

  int errors = 0;
  int checks = 0;
  bit doCheck = 1'b1;

  // Model: edge number, outstanding requests, and the time stamps of the
  // current sequence (grant edge, first edge with OUT low, first idle edge).
  int t = 0;
  bit mPend[NREQ];
  int mPtr, grantT, outEnd, idleAt, grantIdx, mTrig, mDrop;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (edge %0d)", tag, observed, expected, t);
    end
  endtask

  task automatic modelStep();
    int sel, drops, w, idx;
    bit grantNow, clr;
    t++;
    if (RST) begin
      foreach (mPend[i]) mPend[i] = 1'b0;
      mPtr = 0; grantT = -10; outEnd = -10; idleAt = t; grantIdx = 0;
      mTrig = 0; mDrop = 0;
      return;
    end
    if (t == outEnd) idleAt = t + int'(DEAD_TIME);
    sel = -1;
    if (ENABLE && (t - 1 >= idleAt)) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = (mPtr + k) % NREQ;
        if (sel < 0 && mPend[idx]) sel = idx;
      end
    end
    grantNow = (sel >= 0);
    if (grantNow) begin
      w = (PULSE_WIDTH == 0) ? 1 : int'(PULSE_WIDTH);
      grantT = t; outEnd = t + w; idleAt = NEVER; grantIdx = sel;
      mPtr = (sel + 1) % NREQ;
    end
    drops = 0;
    for (int i = 0; i < NREQ; i++) begin
      if (!ENABLE) mPend[i] = 1'b0;
      else begin
        clr = grantNow && (sel == i);
        if (REQ[i] && mPend[i] && !clr) drops++;
        mPend[i] = (mPend[i] && !clr) || REQ[i];
      end
    end
    if (CLR_CNT) begin
      mTrig = 0; mDrop = 0;
    end else begin
      mTrig = (mTrig + int'(grantNow) > 65535) ? 65535 : mTrig + int'(grantNow);
      mDrop = (mDrop + drops > 65535) ? 65535 : mDrop + drops;
    end
  endtask

  task automatic compareAll();
    checkOutput("out", 32'(OUT), 32'((t >= grantT) && (t < outEnd)));
    checkOutput("grant", 32'(GRANT), (t == grantT) ? (32'd1 << grantIdx) : 32'd0);
    checkOutput("busy", 32'(BUSY), 32'((t >= grantT) && (t < idleAt)));
    checkOutput("trig_cnt", 32'(TRIG_CNT), 32'(mTrig));
    checkOutput("drop_cnt", 32'(DROP_CNT), 32'(mDrop));
  endtask

  task automatic applyStimulus(input bit rstIn, input bit enIn, input logic [NREQ-1:0] reqIn,
                               input int pwIn, input int dtIn, input bit clrIn);
    RST = rstIn; ENABLE = enIn; REQ = reqIn; CLR_CNT = clrIn;
    PULSE_WIDTH = WBITS'(pwIn); DEAD_TIME = DBITS'(dtIn);
    @(posedge CLK);
    modelStep();
    #1;
    if (doCheck) compareAll();
  endtask

  // Idle steps with current settings, counting OUT/BUSY cycles and grants.
  task automatic runCount(input int n, output int outHigh, output int busyHigh, output int grants);
    outHigh = 0; busyHigh = 0; grants = 0;
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, ENABLE, '0, int'(PULSE_WIDTH), int'(DEAD_TIME), 1'b0);
      outHigh += int'(OUT); busyHigh += int'(BUSY); grants += int'(GRANT != '0);
    end
  endtask

  int oh, bh, gc, diff;
  logic [NREQ-1:0] gq[$];
  int gt[$];
  logic [NREQ-1:0] rreq;

  initial begin
    RST = 1'b1; ENABLE = 1'b1; REQ = '0; PULSE_WIDTH = '0; DEAD_TIME = '0; CLR_CNT = 1'b0;

    applyStimulus(1, 1, '0, 5, 3, 0);
    applyStimulus(1, 1, '0, 5, 3, 0);

    // Single request
    applyStimulus(0, 1, 4'b0100, 5, 3, 0);
    gc = 0;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(0, 1, '0, 5, 3, 0);
      if (i == 0) checkOutput("single_grant", 32'(GRANT), 32'h4);
      oh += 0;
      if (i == 0) begin oh = 0; bh = 0; end
      oh += int'(OUT); bh += int'(BUSY);
    end
    checkOutput("single_out_len", oh, 5);
    checkOutput("single_busy_len", bh, 8);
    checkOutput("single_trig", 32'(TRIG_CNT), 1);

    // Round-robin fairness from a fresh reset
    applyStimulus(1, 1, '0, 1, 0, 0);
    applyStimulus(0, 1, 4'b1111, 1, 0, 0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, 1, '0, 1, 0, 0);
      if (GRANT != '0) begin gq.push_back(GRANT); gt.push_back(t); end
    end
    checkOutput("rr_count", gq.size(), 4);
    for (int i = 0; i < gq.size() && i < 4; i++) begin
      checkOutput("rr_order", 32'(gq[i]), 32'd1 << i);
      if (i > 0) checkOutput("rr_spacing", gt[i] - gt[i-1], 2);
    end
    checkOutput("rr_drop", 32'(DROP_CNT), 0);

    // Drops while the source already has a request waiting
    for (int c = 0; c <= 12; c++)
      applyStimulus(0, 1, (c == 0 || c == 3 || c == 5 || c == 7 || c == 12) ? 4'b0010 : 4'b0000, 10, 0, 0);
    runCount(30, oh, bh, gc);
    checkOutput("drop_count", 32'(DROP_CNT), 2);
    checkOutput("drop_regrant", gc, 1);

    // Zero pulse width and zero dead time
    applyStimulus(0, 1, 4'b0001, 0, 0, 0);
    runCount(4, oh, bh, gc);
    checkOutput("pw0_out_len", oh, 1);
    checkOutput("pw0_busy_len", bh, 1);

    // ENABLE low during a pulse
    applyStimulus(0, 1, 4'b0001, 6, 2, 0);
    applyStimulus(0, 1, 4'b0010, 6, 2, 0);
    oh = int'(OUT); bh = int'(BUSY);
    applyStimulus(0, 0, 4'b0100, 6, 2, 0);
    oh += int'(OUT); bh += int'(BUSY); gc = int'(GRANT != '0);
    applyStimulus(0, 0, 4'b0110, 6, 2, 0);
    oh += int'(OUT); bh += int'(BUSY); gc += int'(GRANT != '0);
    runCount(6, diff, bh, gc);
    oh += diff;
    ENABLE = 1'b1;
    runCount(12, diff, gc, gc);
    checkOutput("en_out_len", oh + diff, 6);
    checkOutput("en_no_grant", gc, 0);
    checkOutput("en_drop", 32'(DROP_CNT), 2);

    // CLR_CNT together with a drop
    applyStimulus(0, 1, 4'b0100, 8, 0, 0);
    applyStimulus(0, 1, 4'b0000, 8, 0, 0);
    applyStimulus(0, 1, 4'b0100, 8, 0, 0);
    applyStimulus(0, 1, 4'b0000, 8, 0, 0);
    applyStimulus(0, 1, 4'b0100, 8, 0, 1);
    checkOutput("clr_drop", 32'(DROP_CNT), 0);
    checkOutput("clr_trig", 32'(TRIG_CNT), 0);
    runCount(25, oh, bh, gc);

    // Reset in the middle of a pulse, then source 0 first
    applyStimulus(0, 1, 4'b1000, 20, 0, 0);
    runCount(3, oh, bh, gc);
    applyStimulus(1, 1, '0, 20, 0, 0);
    checkOutput("rst_out", 32'(OUT), 0);
    checkOutput("rst_busy", 32'(BUSY), 0);
    checkOutput("rst_trig", 32'(TRIG_CNT), 0);
    applyStimulus(0, 1, 4'b1111, 2, 0, 0);
    applyStimulus(0, 1, 4'b0000, 2, 0, 0);
    checkOutput("rst_first_grant", 32'(GRANT), 32'h1);

    // Drop counter saturation under a very long dead time
    applyStimulus(1, 1, '0, 255, 60000, 0);
    applyStimulus(0, 1, 4'b0001, 255, 60000, 0);
    doCheck = 1'b0;
    for (int i = 0; i < 20000 && mDrop < 16'hFFFE; i++) begin
      diff = 16'hFFFE - mDrop;
      rreq = (diff >= 4) ? 4'hF : NREQ'((1 << diff) - 1);
      applyStimulus(0, 1, rreq, 255, 60000, 0);
    end
    doCheck = 1'b1;
    checkOutput("sat_pre", 32'(DROP_CNT), 32'hFFFE);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 4'b0001, 255, 60000, 0);
    checkOutput("sat_drop", 32'(DROP_CNT), 32'hFFFF);
    applyStimulus(1, 1, '0, 1, 0, 0);

    // Random traffic, including mid-sequence width/dead changes
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < NREQ; b++) rreq[b] = ($urandom_range(0, 6) == 0);
      applyStimulus($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0, rreq,
                    $urandom_range(0, 6), $urandom_range(0, 4), $urandom_range(0, 49) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rd_trig_sched.md
# rd_trig_sched

Round-robin trigger scheduler for the fake radio-detector trigger path. Collects single-cycle trigger requests from up to NREQ sources, grants one at a time, and drives a single output pulse of programmable width followed by a programmable dead time. It replaces the free-running fixed-length stretch on the trigger line with a sequenced, shared, dead-time-protected pulse. It also counts issued pulses and dropped requests for slow-control readout.

## Interface
- NREQ, 4, number of request sources (2..8)
- WBITS, 8, width of PULSE_WIDTH
- DBITS, 16, width of DEAD_TIME
- CLK  in  1  system clock; all logic on rising edge
- RST  in  1  synchronous, active-high reset
- ENABLE  in  1  scheduler enable; low = new requests ignored
- REQ  in  NREQ  per-source request pulses; any high cycle is one request
- PULSE_WIDTH  in  WBITS  output pulse length in cycles (0 treated as 1)
- DEAD_TIME  in  DBITS  idle cycles after pulse before next grant (0 = none)
- CLR_CNT  in  1  clears DROP_CNT and TRIG_CNT
- OUT  out  1  registered trigger pulse
- GRANT  out  NREQ  one-hot, high for one cycle on the cycle OUT rises
- BUSY  out  1  high in PULSE and DEAD states
- TRIG_CNT  out  16  pulses issued, saturating
- DROP_CNT  out  16  requests lost, saturating

## Operation
- Reset values: OUT=0, GRANT=0, BUSY=0, TRIG_CNT=0, DROP_CNT=0, pending=0, state=IDLE, RR pointer=0.
- Pending register: REQ[i]=1 with ENABLE=1 sets pending[i]. If pending[i] is already 1 and is not cleared by a grant in the same cycle, the request is dropped. DROP_CNT += number of dropped bits that cycle, saturating at 0xFFFF.
- ENABLE=0: REQ ignored (no pending, no drop); pending cleared; any pulse/dead sequence in progress runs to completion.
- States:
  - IDLE: if any pending, the RR arbiter selects the first pending index at or after the pointer, wrapping. Next edge: GRANT=onehot(sel), OUT=1, pending[sel] cleared, pointer=sel+1 mod NREQ, width counter loaded with max(PULSE_WIDTH,1)-1, state goes to PULSE, TRIG_CNT+1 (saturating).
  - PULSE: OUT=1. Counter decrements. At 0: if DEAD_TIME=0, go to IDLE; otherwise load DEAD_TIME-1 and go to DEAD. OUT=0 in both cases.
  - DEAD: OUT=0. Counter decrements. At 0, go to IDLE.
- PULSE_WIDTH and DEAD_TIME are sampled only at grant and at PULSE exit respectively. Changes mid-sequence take effect on the next sequence.
- Requests arriving in PULSE/DEAD are held pending. Only a second request from the same source before its grant is dropped.
- CLR_CNT: both counters go to 0 on the next edge. CLR_CNT wins over a simultaneous increment.
- RST mid-sequence: OUT drops on the next edge; all state returns to reset values.

## Timing
- REQ[i] high at edge k sets pending at k. From IDLE, OUT and GRANT are high after edge k+1. Request-to-pulse latency is 2 cycles.
- OUT high for exactly max(PULSE_WIDTH,1) cycles, then low for DEAD_TIME cycles.
- Back-to-back grants: with a pending request and DEAD_TIME=0, the period between OUT rises is max(PULSE_WIDTH,1)+1 cycles (1 IDLE cycle).
- BUSY is high from the edge OUT rises through the last DEAD cycle. It is low in IDLE.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package/header rd_trig_pkg: state encoding (IDLE, PULSE, DEAD), counter width 16, saturation constant 16'hFFFF.
- Sub-module rd_rr_arbiter: pending vector plus pointer in, one-hot select and valid out. Purely combinational, parameterized by NREQ.
- Top holds the FSM, the shared width/dead counter (max(WBITS,DBITS) bits), the pending register and the statistics counters.

## Test plan
- Single request: PULSE_WIDTH=5, DEAD_TIME=3, REQ[2] pulse at edge 10 -> GRANT=4'b0100 and OUT high at edges 12-16, BUSY through edge 19, TRIG_CNT=1.
- Round-robin fairness: REQ=4'b1111 in one cycle, width=1, dead=0 -> grants in order 0,1,2,3, each 2 cycles apart, DROP_CNT=0.
- Drop: width=10, REQ[1] three times during PULSE -> one grant later, DROP_CNT=2. REQ[1] on the grant-clearing cycle of source 1 -> no drop.
- Edge values: PULSE_WIDTH=0 -> 1-cycle OUT. DEAD_TIME=0 -> no DEAD state. Saturation: preload 0xFFFE drops, then 3 drops -> DROP_CNT=0xFFFF.
- ENABLE low mid-pulse: pulse completes, pending cleared, REQ while low -> no grant, no drop. CLR_CNT together with a drop -> DROP_CNT=0.
- RST asserted in PULSE -> OUT=0, BUSY=0, counters 0 after the next edge. A request after reset -> source 0 is checked first.
